// File: rtl/ps2_kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ps2_kbd_pkg
// Purpose : Shared definitions for the PS/2 keyboard receiver: receive FSM
//           state encoding, frame geometry, default parameter values and a
//           parity helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package ps2_kbd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   // start + 8 data + parity + stop
   localparam int unsigned FRAME_BITS = 11;

   localparam int unsigned DEF_FILTER_LEN = 8;
   localparam int unsigned DEF_TIMEOUT    = 50000;
   localparam int unsigned DEF_FIFO_DEPTH = 8;

   // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Purpose : Single-clock first-word-fall-through FIFO with occupancy count.
//           A write while full is accepted only when a read happens in the
//           same cycle; otherwise it is silently dropped.
// Ports   : clk, reset        - clock, synchronous active-high reset
//           wr_en, wr_data    - write request and data
//           rd_en             - pop the head entry (ignored when empty)
//           rd_data           - head entry, zero when empty
//           count             - entries held
//           full, empty       - status flags
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign do_rd = rd_en & ~empty;
   // when full, a write is legal only because the head slot frees up this cycle
   assign do_wr = wr_en & (~full | do_rd);

   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module  : ps2_kbd_rx
// Purpose : PS/2 keyboard receiver. Synchronises and de-glitches the PS/2
//           clock, deserialises 11-bit frames on filtered falling edges,
//           checks odd parity and stop bit, aborts stalled frames and queues
//           good scan codes in a FIFO.
// Ports   : clk, reset          - system clock, synchronous active-high reset
//           ps2_clk, ps2_data   - asynchronous PS/2 lines
//           rx_data, rx_valid   - scan code at FIFO head, FIFO non-empty
//           rx_ready            - consumer pops head when rx_valid & rx_ready
//           fifo_count          - entries held
//           parity_err          - pulse: frame dropped for bad parity
//           frame_err           - pulse: frame dropped for stop=0 or timeout
//           overflow            - pulse: good frame dropped, FIFO full
//           busy                - frame in progress
// Revision: 1.0 - initial release
// ============================================================================
module ps2_kbd_rx
   import ps2_kbd_pkg::*;
#(
   parameter int unsigned FILTER_LEN = DEF_FILTER_LEN,
   parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          parity_err,
   output logic                          frame_err,
   output logic                          overflow,
   output logic                          busy
);

   localparam int unsigned DATA_BITS = FRAME_BITS - 3;
   localparam int unsigned FW        = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW        = $clog2(TIMEOUT + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

   // ---------------------------------------------------------------- sync
   logic clk_s1, clk_s2, dat_s1, dat_s2;

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   // -------------------------------------------------------------- filter
   // filt_cnt counts consecutive samples that disagree with the filtered
   // level; any agreeing sample restarts the count, so short glitches vanish.
   logic          filt_clk;
   logic [FW-1:0] filt_cnt;
   logic          fall;

   assign fall = filt_clk & ~clk_s2 & (filt_cnt == FILT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         filt_clk <= 1'b1;
         filt_cnt <= '0;
      end else if (clk_s2 == filt_clk) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
         filt_clk <= clk_s2;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
      end
   end

   // ----------------------------------------------------------------- FSM
   state_t        state;
   logic [2:0]    bit_cnt;
   logic [TW-1:0] to_cnt;
   logic [7:0]    shreg;
   logic          par_bit;
   logic          push;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         to_cnt     <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         push       <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         push       <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;

         if (state == IDLE || fall) to_cnt <= '0;
         else                       to_cnt <= to_cnt + 1'b1;

         if (state != IDLE && !fall && to_cnt == TO_LAST) begin
            // stalled frame: abandon whatever was collected
            state     <= IDLE;
            bit_cnt   <= '0;
            frame_err <= 1'b1;
         end else if (fall) begin
            case (state)
               IDLE: begin
                  // a high start bit is line noise, not a frame
                  if (!dat_s2) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  shreg <= {dat_s2, shreg[7:1]};
                  if (bit_cnt == BIT_LAST) begin
                     state   <= PARITY;
                     bit_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               PARITY: begin
                  par_bit <= dat_s2;
                  state   <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (!dat_s2)                              frame_err  <= 1'b1;
                  else if (!odd_parity_ok(shreg, par_bit))  parity_err <= 1'b1;
                  else                                      push       <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign busy = (state != IDLE);

   // ---------------------------------------------------------------- FIFO
   logic fifo_full;
   logic fifo_empty;
   logic pop;

   assign rx_valid = ~fifo_empty;
   assign pop      = rx_valid & rx_ready;

   // shreg is not disturbed until the next frame's data bits, so it still
   // holds the completed byte during the push cycle
   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push),
      .wr_data (shreg),
      .rd_en   (rx_ready),
      .rd_data (rx_data),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) overflow <= 1'b0;
      else       overflow <= push & fifo_full & ~pop;
   end

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_ps2_kbd_rx
// Purpose : Self-checking bench for ps2_kbd_rx: frame vector table, FIFO
//           overflow / simultaneous push-pop, timeout, glitch and reset
//           sequences, and randomized frames against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_rx;
   import ps2_kbd_pkg::*;

   localparam int TO    = 400;
   localparam int HALF  = 16;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [3:0] fifo_count;
   logic       parity_err;
   logic       frame_err;
   logic       overflow;
   logic       busy;

   ps2_kbd_rx #(
      .FILTER_LEN (8),
      .TIMEOUT    (TO),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .fifo_count (fifo_count),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overflow   (overflow),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   int pe_tot = 0;
   int fe_tot = 0;
   int ov_tot = 0;

   // pulse-cycle totals; a pulse lasting two cycles counts twice
   always @(negedge clk) begin
      pe_tot <= pe_tot + int'(parity_err);
      fe_tot <= fe_tot + int'(frame_err);
      ov_tot <= ov_tot + int'(overflow);
   end

   bit         rnd_on = 1'b0;
   bit         pop_on_push = 1'b0;
   int         push_hits = 0;
   logic [7:0] q[$];

   typedef struct {
      logic [7:0] d;
      logic       par;
      logic       stop;
      logic       ok;
      logic       pe;
      logic       fe;
   } vec_t;

   vec_t vt[8];

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   function automatic logic good_par(input logic [7:0] d);
      return ~(^d);
   endfunction

   task automatic tick();
      logic [7:0] e;
      @(negedge clk);
      if (rnd_on) begin
         rx_ready = ($urandom_range(0, 1) == 1);
         if (rx_valid && rx_ready) begin
            if (q.size() == 0) check("rnd_spurious_byte", 1, 0);
            else begin
               e = q.pop_front();
               check("rnd_data", rx_data, e);
            end
         end
      end else if (pop_on_push) begin
         rx_ready = dut.push;
         if (dut.push) push_hits++;
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         ticks(HALF);
         ps2_clk = 1'b0;
         ticks(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      send_bits({stop, par, d, 1'b0}, FRAME_BITS);
      ticks(HALF);
   endtask

   task automatic drain();
      rx_ready = 1'b1;
      ticks(DEPTH + 2);
      rx_ready = 1'b0;
      tick();
   endtask

   initial begin
      int pe0, fe0, ov0, exp_pe, exp_fe, waited;
      logic [7:0] d;
      int kind;
      logic par, stop;

      vt[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[1] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[2] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[5] = '{8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[6] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[7] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

      // ---------------- reset state
      ticks(4);
      reset = 1'b0;
      ticks(2);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_pulses", pe_tot + fe_tot + ov_tot, 0);

      // ---------------- frame table
      for (int v = 0; v < 8; v++) begin
         pe0 = pe_tot; fe0 = fe_tot;
         send_frame(vt[v].d, vt[v].par, vt[v].stop);
         ticks(4);
         check($sformatf("vec%0d_count", v), fifo_count, int'(vt[v].ok));
         check($sformatf("vec%0d_valid", v), rx_valid, int'(vt[v].ok));
         check($sformatf("vec%0d_data", v), rx_data, vt[v].ok ? int'(vt[v].d) : 0);
         check($sformatf("vec%0d_parity_err", v), pe_tot - pe0, int'(vt[v].pe));
         check($sformatf("vec%0d_frame_err", v), fe_tot - fe0, int'(vt[v].fe));
         check($sformatf("vec%0d_busy", v), busy, 0);
         drain();
      end

      // ---------------- glitches on idle-high clock
      pe0 = pe_tot; fe0 = fe_tot;
      for (int g = 0; g < 5; g++) begin
         ps2_data = g[0];
         ps2_clk = 1'b0;
         ticks(2);
         ps2_clk = 1'b1;
         ticks(10);
      end
      ps2_data = 1'b1;
      check("glitch_busy", busy, 0);
      check("glitch_count", fifo_count, 0);
      check("glitch_errs", (pe_tot - pe0) + (fe_tot - fe0), 0);

      // ---------------- reset in the middle of a frame
      send_bits(11'b000_0000_1010, 4);
      check("midrst_busy_before", busy, 1);
      reset = 1'b1;
      ticks(2);
      reset = 1'b0;
      ticks(2 * HALF);
      check("midrst_busy", busy, 0);
      check("midrst_count", fifo_count, 0);
      check("midrst_errs", (pe_tot - pe0) + (fe_tot - fe0), 0);

      // ---------------- timeout
      fe0 = fe_tot;
      send_bits(11'b000_0001_0110, 5);
      check("to_busy_mid", busy, 1);
      ticks(TO / 2);
      check("to_no_early_err", fe_tot - fe0, 0);
      waited = HALF + TO / 2;
      for (int k = 0; k < TO; k++) begin
         if (fe_tot != fe0) break;
         tick();
         waited++;
      end
      ticks(3);
      check("to_frame_err", fe_tot - fe0, 1);
      check("to_latency_window", int'(waited >= TO && waited <= TO + 20), 1);
      check("to_busy_after", busy, 0);
      check("to_count", fifo_count, 0);
      send_frame(8'h5A, 1'b1, 1'b1);
      ticks(4);
      check("to_next_data", rx_data, 8'h5A);
      check("to_next_count", fifo_count, 1);
      drain();

      // ---------------- overflow: 9 frames, no consumer
      ov0 = ov_tot;
      for (int i = 1; i <= 9; i++) send_frame(8'(i), good_par(8'(i)), 1'b1);
      ticks(4);
      check("ovf_count", fifo_count, 8);
      check("ovf_pulses", ov_tot - ov0, 1);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("ovf_drain%0d", i), rx_data, i);
         rx_ready = 1'b1;
         tick();
         rx_ready = 1'b0;
      end
      tick();
      check("ovf_empty", rx_valid, 0);

      // ---------------- full FIFO, push coincides with pop
      ov0 = ov_tot;
      for (int i = 1; i <= 8; i++) send_frame(8'(i), good_par(8'(i)), 1'b1);
      ticks(2);
      check("pp_full_count", fifo_count, 8);
      push_hits = 0;
      pop_on_push = 1'b1;
      send_frame(8'h09, good_par(8'h09), 1'b1);
      pop_on_push = 1'b0;
      rx_ready = 1'b0;
      ticks(2);
      check("pp_push_seen", push_hits, 1);
      check("pp_no_overflow", ov_tot - ov0, 0);
      check("pp_count", fifo_count, 8);
      for (int i = 2; i <= 9; i++) begin
         check($sformatf("pp_drain%0d", i), rx_data, i);
         rx_ready = 1'b1;
         tick();
         rx_ready = 1'b0;
      end
      tick();
      check("pp_empty", fifo_count, 0);

      // ---------------- randomized frames against queue model
      pe0 = pe_tot; fe0 = fe_tot; ov0 = ov_tot;
      exp_pe = 0; exp_fe = 0;
      rnd_on = 1'b1;
      for (int f = 0; f < 24; f++) begin
         d    = 8'($urandom);
         kind = $urandom_range(0, 7);
         par  = good_par(d) ^ (kind == 6);
         stop = (kind != 7);
         if (!stop)                   exp_fe++;
         else if (^{d, par} == 1'b0)  exp_pe++;
         else                         q.push_back(d);
         send_frame(d, par, stop);
      end
      for (int k = 0; k < 200 && q.size() != 0; k++) tick();
      rnd_on = 1'b0;
      rx_ready = 1'b0;
      ticks(2);
      check("rnd_all_received", q.size(), 0);
      check("rnd_count", fifo_count, 0);
      check("rnd_parity_errs", pe_tot - pe0, exp_pe);
      check("rnd_frame_errs", fe_tot - fe0, exp_fe);
      check("rnd_overflow", ov_tot - ov0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
